// File: rtl/pixel_frame_collector.sv
// Collects filtered pixels into a small FIFO, tagging each with frame position
// (sof/eol/eof) from row/col counters, and drains a whole frame before taking the next.
module pixel_frame_collector #(
  parameter int WIDTH = 8,
  parameter int COLS  = 256,
  parameter int ROWS  = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat transfers on a posedge where valid && ready, on both sides.
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 3;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_in_ready;
  logic          r_frame_done;
  logic          r_overflow;

  logic          w_wr;
  logic          w_rd;
  logic          w_sof;
  logic          w_eol;
  logic          w_eof;
  logic [EW-1:0] w_head;
  logic [AW:0]   w_count_nxt;
  state_t        w_state_nxt;

  always_comb begin
    w_wr   = in_valid && r_in_ready;
    w_rd   = (r_count != '0) && out_ready;
    w_sof  = (r_col == '0) && (r_row == '0);
    w_eol  = (r_col == COL_LAST);
    w_eof  = w_eol && (r_row == ROW_LAST);
    w_head = r_mem[r_rd_ptr];

    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_wr) w_state_nxt = w_eof ? S_FLUSH : S_ACTIVE;
      S_ACTIVE: if (w_wr && w_eof) w_state_nxt = S_FLUSH;
      // Nothing is written in FLUSH, so the last entry read is the eof entry.
      S_FLUSH:  if (w_rd && (r_count == CNT_ONE)) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_in_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      // Ready is registered from the next occupancy, so a full FIFO never passes through.
      r_in_ready   <= (w_state_nxt != S_FLUSH) && (w_count_nxt != CNT_FULL);
      r_frame_done <= w_rd && w_head[0];
      if (in_valid && !r_in_ready) r_overflow <= 1'b1;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {in_data, w_sof, w_eol, w_eof};
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? w_head[EW-1:3] : '0;
  assign out_sof    = out_valid && w_head[2];
  assign out_eol    = out_valid && w_head[1];
  assign out_eof    = out_valid && w_head[0];
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Bench for pixel_frame_collector: queue-based frame model checked every cycle on a
// 4x2 instance, plus directed literal checks and a 1x1 instance.
module tb_pixel_frame_collector;

  localparam int W     = 8;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_sof;
  logic         out_eol;
  logic         out_eof;
  logic         out_ready;
  logic         frame_done;
  logic         overflow;
  logic [1:0]   dbg_state;

  logic         s_rst;
  logic         s_in_valid;
  logic [W-1:0] s_in_data;
  logic         s_in_ready;
  logic         s_out_valid;
  logic [W-1:0] s_out_data;
  logic         s_out_sof;
  logic         s_out_eol;
  logic         s_out_eof;
  logic         s_out_ready;
  logic         s_frame_done;
  logic         s_overflow;
  logic [1:0]   s_dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  pixel_frame_collector #(.WIDTH(W), .COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .out_ready(out_ready), .frame_done(frame_done),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  pixel_frame_collector #(.WIDTH(W), .COLS(1), .ROWS(1), .DEPTH(DEPTH)) u_dut_1x1 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sof(s_out_sof), .out_eol(s_out_eol),
    .out_eof(s_out_eof), .out_ready(s_out_ready), .frame_done(s_frame_done),
    .overflow(s_overflow), .dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each entry is {data, sof, eol, eof}
  logic [W+2:0] exp_q[$];
  int           m_pix   = 0;
  bit           m_flush = 1'b0;
  bit           m_ovf   = 1'b0;
  bit           m_fd    = 1'b0;
  bit           m_live  = 1'b0;
  bit           m_rdy;
  bit           e_valid;
  bit           m_rd;
  bit           m_wr;
  logic [W+2:0] m_head;
  logic [W+2:0] m_pop;
  int           m_col;
  int           m_row;

  always @(negedge clk) begin
    m_rdy   = m_live && !m_flush && (exp_q.size() < DEPTH);
    e_valid = (exp_q.size() != 0);
    m_head  = e_valid ? exp_q[0] : '0;
    chk("out_valid",  out_valid,  e_valid);
    chk("out_data",   out_data,   m_head[W+2:3]);
    chk("out_sof",    out_sof,    m_head[2]);
    chk("out_eol",    out_eol,    m_head[1]);
    chk("out_eof",    out_eof,    m_head[0]);
    chk("in_ready",   in_ready,   m_rdy);
    chk("overflow",   overflow,   m_ovf);
    chk("frame_done", frame_done, m_fd);
    chk("dbg_state",  dbg_state,  m_flush ? 2 : (m_pix != 0 ? 1 : 0));

    // Effect of the coming posedge, from the inputs held stable across it.
    if (!rst) begin
      exp_q.delete();
      m_pix = 0; m_flush = 0; m_ovf = 0; m_fd = 0; m_live = 0;
    end else begin
      m_rd = e_valid && out_ready;
      m_wr = in_valid && m_rdy;
      m_fd = 0;
      if (in_valid && !m_rdy) m_ovf = 1;
      if (m_rd) begin
        m_pop = exp_q.pop_front();
        if (m_pop[0]) begin
          m_fd    = 1;
          m_flush = 0;
        end
      end
      if (m_wr) begin
        m_col = m_pix % COLS;
        m_row = m_pix / COLS;
        exp_q.push_back({in_data, (m_col == 0 && m_row == 0), (m_col == COLS - 1),
                         (m_col == COLS - 1 && m_row == ROWS - 1)});
        if (m_col == COLS - 1 && m_row == ROWS - 1) m_flush = 1;
        m_pix = (m_pix + 1) % (COLS * ROWS);
      end
      m_live = 1;
    end
  end

  // Driver tasks
  task automatic set_in(input logic r, input logic v, input logic [W-1:0] d, input logic o);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; out_ready = o;
  endtask

  task automatic set_s(input logic r, input logic v, input logic [W-1:0] d, input logic o);
    @(posedge clk);
    #1;
    s_rst = r; s_in_valid = v; s_in_data = d; s_out_ready = o;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_rst = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("in_ready_rise", in_ready, 1);

    // Full frame streamed with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b1, W'(8'h10 + i), 1'b1);
      if (i == 1) begin
        @(negedge clk);
        chk("first_out_data", out_data, 8'h10);
        chk("first_out_sof", out_sof, 1);
      end
    end
    set_in(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("last_out_data", out_data, 8'h17);
    chk("last_out_eof", out_eof, 1);
    chk("last_out_eol", out_eol, 1);
    set_in(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 1);
    repeat (3) set_in(1'b1, 1'b0, '0, 1'b1);

    // Fill while stalled, fifth pixel is dropped
    for (int i = 0; i < 5; i++) set_in(1'b1, 1'b1, W'(8'h10 + i), 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("full_overflow", overflow, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_data, 8'h10);
    repeat (6) set_in(1'b1, 1'b0, '0, 1'b1);
    do_reset();

    // Offers during FLUSH are rejected, next frame starts with sof
    for (int i = 0; i < 5; i++) set_in(1'b1, 1'b1, W'(8'h20 + i), 1'b1);
    for (int i = 5; i < 8; i++) set_in(1'b1, 1'b1, W'(8'h20 + i), 1'b0);
    repeat (2) set_in(1'b1, 1'b1, 8'h99, 1'b0);
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_overflow", overflow, 1);
    chk("flush_state", dbg_state, 2);
    repeat (6) set_in(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("drained_state", dbg_state, 0);
    set_in(1'b1, 1'b1, 8'h30, 1'b1);
    set_in(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("new_frame_sof", out_sof, 1);
    chk("new_frame_data", out_data, 8'h30);
    do_reset();

    // Steady read+write at two entries
    set_in(1'b1, 1'b1, 8'h40, 1'b0);
    set_in(1'b1, 1'b1, 8'h41, 1'b0);
    for (int i = 2; i < 8; i++) begin
      set_in(1'b1, 1'b1, W'(8'h40 + i), 1'b1);
      if (i == 4) begin
        @(negedge clk);
        chk("stream_head", out_data, 8'h42);
      end
    end
    repeat (4) set_in(1'b1, 1'b0, '0, 1'b1);
    do_reset();

    // Reset mid-frame discards partial content
    for (int i = 0; i < 3; i++) set_in(1'b1, 1'b1, W'(8'h50 + i), 1'b0);
    do_reset();
    @(negedge clk);
    chk("post_reset_empty", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b1, W'(8'hA0 + i), 1'b1);
      if (i == 1) begin
        @(negedge clk);
        chk("post_reset_sof_data", out_data, 8'hA0);
        chk("post_reset_sof", out_sof, 1);
      end
    end
    repeat (4) set_in(1'b1, 1'b0, '0, 1'b1);

    // Single-pixel frames
    set_s(1'b1, 1'b0, '0, 1'b0);
    set_s(1'b1, 1'b0, '0, 1'b0);
    set_s(1'b1, 1'b1, 8'h55, 1'b1);
    set_s(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("px1_valid", s_out_valid, 1);
    chk("px1_data", s_out_data, 8'h55);
    chk("px1_sof", s_out_sof, 1);
    chk("px1_eol", s_out_eol, 1);
    chk("px1_eof", s_out_eof, 1);
    chk("px1_in_ready_flush", s_in_ready, 0);
    set_s(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("px1_frame_done", s_frame_done, 1);
    chk("px1_empty", s_out_valid, 0);
    set_s(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("px1_frame_done_once", s_frame_done, 0);
    chk("px1_in_ready_back", s_in_ready, 1);
    chk("px1_overflow", s_overflow, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_collector.md
PIXEL_FRAME_COLLECTOR -- requirements
Module: pixel_frame_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter COLS, default 256, pixels per line.
REQ-003 SHALL have parameter ROWS, default 256, lines per frame.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  filter output pixel present.
REQ-008 SHALL have port in_data  input  WIDTH  filtered pixel.
REQ-009 SHALL have port in_ready  output  1  collector can accept a pixel this cycle.
REQ-010 SHALL have port out_valid  output  1  head FIFO entry available.
REQ-011 SHALL have port out_data  output  WIDTH  head pixel.
REQ-012 SHALL have port out_sof  output  1  head pixel is row 0, col 0.
REQ-013 SHALL have port out_eol  output  1  head pixel is col COLS-1.
REQ-014 SHALL have port out_eof  output  1  head pixel is row ROWS-1, col COLS-1.
REQ-015 SHALL have port out_ready  input  1  downstream consumes head entry.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse, EOF entry consumed.
REQ-017 SHALL have port overflow  output  1  sticky: pixel offered while in_ready low.

Function
REQ-018 SHALL accept a pixel when in_valid && in_ready; SHALL read the head entry when out_valid && out_ready.
REQ-019 SHALL store per entry {data, sof, eol, eof}, tags derived from col/row counters at write time.
REQ-020 SHALL increment col on each accept; col wraps COLS-1 -> 0 and increments row; row wraps ROWS-1 -> 0 together with col.
REQ-021 SHALL make an accepted pixel visible at out_valid on the next clock edge (1-cycle latency when empty).
REQ-022 SHALL support simultaneous read and write in one cycle when neither full nor empty; occupancy unchanged.
REQ-023 SHALL drive in_ready = 0 when FIFO full, even if out_ready is high that cycle (no pass-through on full).
REQ-024 SHALL drive out_valid = 0 when empty; out_data and all tags SHALL read 0 whenever out_valid = 0.
REQ-025 SHALL hold head entry and tags stable while out_valid && !out_ready.
REQ-026 SHALL implement states IDLE, ACTIVE, FLUSH.
REQ-027 IDLE: in_ready = !full; first accept -> ACTIVE (pixel tagged sof).
REQ-028 ACTIVE: in_ready = !full; accept of eof-tagged pixel -> FLUSH.
REQ-029 FLUSH: in_ready = 0; -> IDLE on the cycle the FIFO becomes empty (eof entry read).
REQ-030 SHALL pulse frame_done exactly one cycle, registered, the cycle after the eof entry is read.
REQ-031 SHALL set overflow on any cycle with in_valid && !in_ready (including FLUSH); cleared only by reset; the offered pixel is dropped and counters do not advance.
REQ-032 With COLS = 1, every pixel SHALL carry eol; with ROWS = COLS = 1, every pixel SHALL carry sof, eol, eof.

Reset
REQ-033 While rst = 0 at a posedge: state IDLE, col = row = 0, FIFO empty, in_ready = 0, out_valid = 0, out_data = 0, tags = 0, frame_done = 0, overflow = 0.
REQ-034 in_ready SHALL rise the first cycle after rst returns to 1.
REQ-035 Reset asserted mid-frame SHALL discard FIFO contents and counters; next accepted pixel is tagged sof.

Verification (COLS=4, ROWS=2, DEPTH=4 unless noted)
REQ-036 Stream 8 pixels 0x10..0x17, out_ready=1 -> out 0x10..0x17 one cycle later each; sof on 0x10, eol on 0x13 and 0x17, eof on 0x17; frame_done one cycle after 0x17 read; overflow=0.
REQ-037 out_ready=0, push 5 pixels -> first 4 accepted, in_ready=0 after 4th, overflow=1 on 5th; release out_ready -> 0x10..0x13 emitted in order, 5th absent.
REQ-038 After eof accepted with out_ready=0, hold in_valid=1 -> in_ready=0, overflow=1; after drain, state IDLE, next pixel tagged sof.
REQ-039 FIFO at 2 entries, in_valid=out_ready=1 for 6 cycles -> occupancy stays 2, order preserved, no gaps on out_valid.
REQ-040 rst=0 after 3 pixels, then new frame 0xA0..0xA7 -> 0xA0 tagged sof, eof on 0xA7, no stale data emitted.
REQ-041 COLS=ROWS=1: single pixel 0x55 -> out_sof=out_eol=out_eof=1, frame_done pulses once.
